// File: rtl/lbp_host_if.sv
// LBP host bus bundle: gray-read and lbp-write handshakes plus the source/destination SRAM ports.
// The slave modport is the lbp_host view; the master modport is the LBP/SRAM-environment view.
interface lbp_host_if;
  logic        start;
  logic        gray_req;
  logic [13:0] gray_addr;
  logic        gray_ready;
  logic [7:0]  gray_data;
  logic        lbp_valid;
  logic [13:0] lbp_addr;
  logic [7:0]  lbp_data;
  logic        finish;
  logic        src_rd;
  logic [13:0] src_addr;
  logic [7:0]  src_q;
  logic        dst_we;
  logic [13:0] dst_addr;
  logic [7:0]  dst_d;
  logic [14:0] wr_count;
  logic        done;

  modport slave (
    input  start, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish, src_q,
    output gray_ready, gray_data, src_rd, src_addr, dst_we, dst_addr, dst_d, wr_count, done
  );

  modport master (
    output start, gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish, src_q,
    input  gray_ready, gray_data, src_rd, src_addr, dst_we, dst_addr, dst_d, wr_count, done
  );
endinterface

// File: rtl/lbp_host.sv
// LBP host responder: serves gray pixels from a synchronous source SRAM with one-cycle latency
// and forwards LBP results to a destination SRAM through a registered write port.
module lbp_host (
  input  logic        clk,
  input  logic        reset,
  lbp_host_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [14:0] WR_MAX = 15'h4000;

  state_e      state_q, state_d;
  logic        rd_pend_q;
  logic [7:0]  gray_data_q;
  logic        dst_we_q;
  logic [13:0] dst_addr_q;
  logic [7:0]  dst_d_q;
  logic [14:0] wr_count_q, wr_count_d;

  logic        serve_s;
  logic        wr_acc_s;
  logic        restart_s;

  assign serve_s   = (state_q == S_SERVE);
  assign wr_acc_s  = serve_s & bus.lbp_valid;
  assign restart_s = ((state_q == S_IDLE) || (state_q == S_DONE)) & bus.start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start)  state_d = S_SERVE; else state_d = S_IDLE;
      S_SERVE: if (bus.finish) state_d = S_DRAIN; else state_d = S_SERVE;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  if (bus.start)  state_d = S_SERVE; else state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Counter clears on frame (re)start and saturates once every pixel has been written.
  always_comb begin
    wr_count_d = wr_count_q;
    if (restart_s) begin
      wr_count_d = 15'd0;
    end else if (wr_acc_s && (wr_count_q != WR_MAX)) begin
      wr_count_d = wr_count_q + 15'd1;
    end else begin
      wr_count_d = wr_count_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_pend_q   <= 1'b0;
      gray_data_q <= 8'h00;
      dst_we_q    <= 1'b0;
      dst_addr_q  <= 14'd0;
      dst_d_q     <= 8'h00;
      wr_count_q  <= 15'd0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      // A read issued on the finish edge still lands in gray_data during DRAIN.
      rd_pend_q  <= bus.src_rd;
      if (rd_pend_q) begin
        gray_data_q <= bus.src_q;
      end
      dst_we_q <= wr_acc_s;
      if (wr_acc_s) begin
        dst_addr_q <= bus.lbp_addr;
        dst_d_q    <= bus.lbp_data;
      end
    end
  end

  assign bus.src_rd     = bus.gray_req & serve_s;
  assign bus.src_addr   = bus.gray_addr;
  assign bus.gray_ready = serve_s;
  assign bus.done       = (state_q == S_DONE);
  assign bus.gray_data  = gray_data_q;
  assign bus.dst_we     = dst_we_q;
  assign bus.dst_addr   = dst_addr_q;
  assign bus.dst_d      = dst_d_q;
  assign bus.wr_count   = wr_count_q;

endmodule

// File: tb/tb_lbp_host.sv
// Directed bench for lbp_host: behavioural synchronous source SRAM, hand-computed expectations.
module tb_lbp_host;

  logic clk;
  logic reset;
  lbp_host_if bus ();

  lbp_host dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem [0:16383];
  int n_cmp;
  int n_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.src_rd) bus.src_q <= mem[bus.src_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(bus.gray_ready), 32'h0);
    chk({tag, "_gdata"}, 32'(bus.gray_data), 32'h00);
    chk({tag, "_we"},    32'(bus.dst_we), 32'h0);
    chk({tag, "_daddr"}, 32'(bus.dst_addr), 32'h0);
    chk({tag, "_dd"},    32'(bus.dst_d), 32'h0);
    chk({tag, "_cnt"},   32'(bus.wr_count), 32'h0);
    chk({tag, "_done"},  32'(bus.done), 32'h0);
  endtask

  logic [7:0]  b2b_exp  [4];
  logic [13:0] b2b_addr [4];

  initial begin
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    bus.start = 1'b0; bus.gray_req = 1'b0; bus.gray_addr = 14'd0;
    bus.lbp_valid = 1'b0; bus.lbp_addr = 14'd0; bus.lbp_data = 8'h00;
    bus.finish = 1'b0; bus.src_q = 8'h00;
    reset = 1'b1;
    #12;
    chk_reset_vals("rst");
    step();
    #2 reset = 1'b0;

    // Stays idle without start; requests outside SERVE are ignored.
    bus.gray_req = 1'b1;
    #1;
    chk("idle_src_rd", 32'(bus.src_rd), 32'h0);
    step(); step();
    chk("idle_ready", 32'(bus.gray_ready), 32'h0);
    chk("idle_gdata", 32'(bus.gray_data), 32'h00);
    bus.gray_req = 1'b0;

    // Single read.
    mem[0] = 8'h5A;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("start_ready", 32'(bus.gray_ready), 32'h1);
    bus.gray_req = 1'b1; bus.gray_addr = 14'h0000;
    #1;
    chk("rd_src_rd", 32'(bus.src_rd), 32'h1);
    chk("rd_src_addr", 32'(bus.src_addr), 32'h0);
    step();
    bus.gray_req = 1'b0;
    chk("rd_lat_pre", 32'(bus.gray_data), 32'h00);
    step();
    chk("rd_data", 32'(bus.gray_data), 32'h5A);

    // Back-to-back reads 0,1,128,129.
    mem[0] = 8'h10; mem[1] = 8'h11; mem[128] = 8'h20; mem[129] = 8'h21;
    b2b_addr[0] = 14'd0;   b2b_addr[1] = 14'd1;   b2b_addr[2] = 14'd128; b2b_addr[3] = 14'd129;
    b2b_exp[0]  = 8'h10;   b2b_exp[1]  = 8'h11;   b2b_exp[2]  = 8'h20;   b2b_exp[3]  = 8'h21;
    for (int i = 0; i < 4; i++) begin
      bus.gray_req = 1'b1; bus.gray_addr = b2b_addr[i];
      step();
      if (i > 0) chk($sformatf("b2b_%0d", i - 1), 32'(bus.gray_data), 32'(b2b_exp[i - 1]));
    end
    bus.gray_req = 1'b0;
    step();
    chk("b2b_3", 32'(bus.gray_data), 32'h21);
    step();
    chk("b2b_hold", 32'(bus.gray_data), 32'h21);

    // Single write.
    bus.lbp_valid = 1'b1; bus.lbp_addr = 14'h0081; bus.lbp_data = 8'hC3;
    step();
    bus.lbp_valid = 1'b0;
    chk("wr_we", 32'(bus.dst_we), 32'h1);
    chk("wr_addr", 32'(bus.dst_addr), 32'h0081);
    chk("wr_d", 32'(bus.dst_d), 32'hC3);
    chk("wr_cnt", 32'(bus.wr_count), 32'h1);
    step();
    chk("wr_we_off", 32'(bus.dst_we), 32'h0);

    // Fill to saturation, then same-address writes past the limit.
    for (int i = 0; i < 16382; i++) begin
      bus.lbp_valid = 1'b1; bus.lbp_addr = 14'(i); bus.lbp_data = 8'(i);
      step();
    end
    chk("cnt_3fff", 32'(bus.wr_count), 32'h3FFF);
    bus.lbp_addr = 14'h0100; bus.lbp_data = 8'hAB;
    step();
    chk("cnt_4000", 32'(bus.wr_count), 32'h4000);
    bus.lbp_addr = 14'h0005; bus.lbp_data = 8'h11;
    step();
    chk("sat1_cnt", 32'(bus.wr_count), 32'h4000);
    chk("dup1_d", 32'(bus.dst_d), 32'h11);
    bus.lbp_data = 8'h22;
    step();
    chk("sat2_cnt", 32'(bus.wr_count), 32'h4000);
    chk("dup2_we", 32'(bus.dst_we), 32'h1);
    chk("dup2_addr", 32'(bus.dst_addr), 32'h0005);
    chk("dup2_d", 32'(bus.dst_d), 32'h22);

    // finish with a simultaneous write and read.
    mem[129] = 8'h99;
    bus.finish = 1'b1; bus.lbp_addr = 14'h3FFF; bus.lbp_data = 8'h7E;
    bus.gray_req = 1'b1; bus.gray_addr = 14'd129;
    step();
    bus.finish = 1'b0; bus.gray_req = 1'b0;
    bus.lbp_addr = 14'h1234; bus.lbp_data = 8'hEE;
    bus.start = 1'b1;
    chk("drain_ready", 32'(bus.gray_ready), 32'h0);
    chk("drain_we", 32'(bus.dst_we), 32'h1);
    chk("drain_addr", 32'(bus.dst_addr), 32'h3FFF);
    chk("drain_d", 32'(bus.dst_d), 32'h7E);
    chk("drain_done", 32'(bus.done), 32'h0);
    step();
    bus.start = 1'b0;
    chk("done_done", 32'(bus.done), 32'h1);
    chk("done_we", 32'(bus.dst_we), 32'h0);
    chk("done_rd_tail", 32'(bus.gray_data), 32'h99);
    chk("done_cnt", 32'(bus.wr_count), 32'h4000);
    bus.gray_req = 1'b1; bus.gray_addr = 14'd0;
    #1;
    chk("done_src_rd", 32'(bus.src_rd), 32'h0);
    step(); step();
    bus.gray_req = 1'b0; bus.lbp_valid = 1'b0;
    chk("done_gdata_hold", 32'(bus.gray_data), 32'h99);
    chk("done_we_drop", 32'(bus.dst_we), 32'h0);
    chk("done_hold", 32'(bus.done), 32'h1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("restart_ready", 32'(bus.gray_ready), 32'h1);
    chk("restart_cnt", 32'(bus.wr_count), 32'h0);
    chk("restart_done", 32'(bus.done), 32'h0);

    // Reset while a write and a read are in flight.
    bus.lbp_valid = 1'b1; bus.lbp_addr = 14'h0042; bus.lbp_data = 8'h55;
    bus.gray_req = 1'b1; bus.gray_addr = 14'd1;
    #1 reset = 1'b1;
    #1;
    chk_reset_vals("mid_rst");
    step();
    bus.lbp_valid = 1'b0; bus.gray_req = 1'b0;
    chk_reset_vals("mid_rst_hold");
    #2 reset = 1'b0;
    step(); step();
    chk_reset_vals("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
